// File: rtl/tri_reader.sv
// Block fetcher: queues block-index requests and assembles 2*NDWORDS halfword reads into one block.
// Optional 8-line direct-mapped block cache when TRI_READER_CACHE_EN is defined.
module tri_reader #(
    parameter int NDWORDS = 1,
    parameter int QDEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             baseaddr,
    input  logic [31:0]             index,
    input  logic                    read,
    output logic [32*NDWORDS-1:0]   data,
    output logic                    ovalid,
    output logic                    iready,
    output logic                    avm_m0_read,
    output logic                    avm_m0_write,
    output logic [15:0]             avm_m0_writedata,
    output logic [31:0]             avm_m0_address,
    input  logic [15:0]             avm_m0_readdata,
    input  logic                    avm_m0_readdatavalid,
    output logic [1:0]              avm_m0_byteenable,
    input  logic                    avm_m0_waitrequest
);

    localparam int BLOCKSZ = 32 * NDWORDS;
    localparam int NHALF   = 2 * NDWORDS;
    localparam int KW      = $clog2(NHALF) + 1;
    localparam int PW      = $clog2(QDEPTH);
    localparam int CW      = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t state_reg, state_next;

    logic [31:0]        fifo_mem [QDEPTH];
    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      count_reg, count_next;
    logic               iready_reg;
    logic               push, pop, fifo_empty;
    logic [31:0]        head_index;

    logic [31:0]        addr_base_reg;
    logic [KW-1:0]      k_reg, rcnt_reg;
    logic [BLOCKSZ-1:0] shreg_reg, data_reg, assembled;
    logic               ovalid_reg;

    logic               issue_acc, issue_last, rsp, rsp_last;
    logic               cache_hit;
    logic [BLOCKSZ-1:0] cache_line;

    assign fifo_empty = (count_reg == '0);
    assign head_index = fifo_mem[rd_ptr_reg];
    assign push       = read && iready_reg;
    assign count_next = count_reg + CW'(push) - CW'(pop);

    assign issue_acc  = (state_reg == S_ISSUE) && !avm_m0_waitrequest;
    assign issue_last = issue_acc && (k_reg == KW'(NHALF - 1));
    // Responses only count while a block is outstanding; stray or post-reset beats are dropped.
    assign rsp        = avm_m0_readdatavalid && (state_reg != S_IDLE);
    assign rsp_last   = rsp && (rcnt_reg == KW'(NHALF - 1));
    assign assembled  = {shreg_reg[BLOCKSZ-17:0], avm_m0_readdata};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= index;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (pop && !cache_hit) state_next = S_ISSUE;
            S_ISSUE: if (issue_last)        state_next = S_WAIT;
            S_WAIT:  if (rsp_last)          state_next = S_IDLE;
            default:                        state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pop         = 1'b0;
        avm_m0_read = 1'b0;
        case (state_reg)
            S_IDLE:  pop         = !fifo_empty;
            S_ISSUE: avm_m0_read = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            iready_reg    <= 1'b1;
            addr_base_reg <= '0;
            k_reg         <= '0;
            rcnt_reg      <= '0;
            shreg_reg     <= '0;
            data_reg      <= '0;
            ovalid_reg    <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg  <= count_next;
            iready_reg <= (count_next != CW'(QDEPTH));
            ovalid_reg <= 1'b0;
            if (pop) begin
                addr_base_reg <= baseaddr + head_index * 32'(4 * NDWORDS);
                k_reg         <= '0;
                rcnt_reg      <= '0;
                if (cache_hit) begin
                    data_reg   <= cache_line;
                    ovalid_reg <= 1'b1;
                end
            end
            if (issue_acc) k_reg <= k_reg + KW'(1);
            if (rsp) begin
                shreg_reg <= assembled;
                rcnt_reg  <= rcnt_reg + KW'(1);
            end
            if (rsp_last) begin
                data_reg   <= assembled;
                ovalid_reg <= 1'b1;
            end
        end
    end

`ifdef TRI_READER_CACHE_EN
    logic [7:0]         valid_reg;
    logic [28:0]        tag_mem  [8];
    logic [BLOCKSZ-1:0] line_mem [8];
    logic [31:0]        idx_reg;

    assign cache_hit  = valid_reg[head_index[2:0]] && (tag_mem[head_index[2:0]] == head_index[31:3]);
    assign cache_line = line_mem[head_index[2:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_reg   <= '0;
            valid_reg <= '0;
        end else begin
            if (pop) idx_reg <= head_index;
            for (int i = 0; i < 8; i++) begin
                if (rsp_last && (idx_reg[2:0] == 3'(i))) valid_reg[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_last) begin
            line_mem[idx_reg[2:0]] <= assembled;
            tag_mem[idx_reg[2:0]]  <= idx_reg[31:3];
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_line = '0;
`endif

    assign data              = data_reg;
    assign ovalid            = ovalid_reg;
    assign iready            = iready_reg;
    assign avm_m0_address    = addr_base_reg + (32'(k_reg) << 1);
    assign avm_m0_write      = 1'b0;
    assign avm_m0_writedata  = 16'h0000;
    assign avm_m0_byteenable = 2'b11;

endmodule

// File: tb/tb_tri_reader.sv
// Self-checking bench for tri_reader (NDWORDS=1): table vectors, scoreboard on ovalid, address queue on bus.
module tb_tri_reader;

    localparam int NDWORDS = 1;
    localparam int QDEPTH  = 4;
`ifdef TRI_READER_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] baseaddr;
    logic [31:0] index;
    logic        read;
    logic [31:0] data;
    logic        ovalid, iready;
    logic        avm_m0_read, avm_m0_write;
    logic [15:0] avm_m0_writedata;
    logic [31:0] avm_m0_address;
    logic [15:0] avm_m0_readdata;
    logic        avm_m0_readdatavalid;
    logic [1:0]  avm_m0_byteenable;
    logic        avm_m0_waitrequest;

    tri_reader #(.NDWORDS(NDWORDS), .QDEPTH(QDEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .baseaddr             (baseaddr),
        .index                (index),
        .read                 (read),
        .data                 (data),
        .ovalid               (ovalid),
        .iready               (iready),
        .avm_m0_read          (avm_m0_read),
        .avm_m0_write         (avm_m0_write),
        .avm_m0_writedata     (avm_m0_writedata),
        .avm_m0_address       (avm_m0_address),
        .avm_m0_readdata      (avm_m0_readdata),
        .avm_m0_readdatavalid (avm_m0_readdatavalid),
        .avm_m0_byteenable    (avm_m0_byteenable),
        .avm_m0_waitrequest   (avm_m0_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] d;
    } rsp_t;

    logic [15:0] mem [256];
    logic [31:0] sb_q[$];
    logic [31:0] addr_q[$];
    rsp_t        rsp_q[$];
    vec_t        vecs[3];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int bus_reads = 0;
    int stall_left = 0;
    bit stall_seen = 0;
    bit silent = 0;
    bit stray  = 0;
    logic [31:0] held_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
            $display("ok   %s: got %h", name, act);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] blk(input logic [31:0] idx);
        int h;
        h = int'((baseaddr + idx * 32'd4) >> 1);
        return {mem[h % 256], mem[(h + 1) % 256]};
    endfunction

    // Avalon slave model: waitrequest stalls on demand, responses return 2 cycles after acceptance.
    always @(negedge clk) begin
        cyc++;
        avm_m0_readdatavalid = 1'b0;
        avm_m0_readdata      = 16'h0000;
        if (!silent && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = rsp_q[0].d;
            void'(rsp_q.pop_front());
        end else if (stray) begin
            avm_m0_readdatavalid = 1'b1;
            avm_m0_readdata      = 16'hdead;
            stray                = 1'b0;
        end
        avm_m0_waitrequest = 1'b0;
        if (avm_m0_read) begin
            if (stall_left > 0) begin
                avm_m0_waitrequest = 1'b1;
                stall_left--;
                if (stall_seen) begin
                    check("stall_addr_stable", avm_m0_address, held_addr);
                end else begin
                    held_addr  = avm_m0_address;
                    stall_seen = 1'b1;
                end
            end else begin
                if (stall_seen) begin
                    check("stall_release_addr", avm_m0_address, held_addr);
                    stall_seen = 1'b0;
                end
                bus_reads++;
                if (addr_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_read: got addr %h expected no bus read", avm_m0_address);
                end else begin
                    check("bus_addr", avm_m0_address, addr_q.pop_front());
                end
                rsp_q.push_back('{cyc + 2, mem[(avm_m0_address >> 1) % 256]});
            end
        end
    end

    // Output monitor: every ovalid pulse pops one expected block.
    always @(negedge clk) begin
        if (ovalid) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ovalid: got data %h expected no output", data);
            end else begin
                check("block_data", data, sb_q.pop_front());
            end
        end
    end

    task automatic req(input logic [31:0] idx, input bit acc, input bit bus,
                       input bit push_sb, input logic [31:0] expd);
        logic [31:0] a;
        check("iready_before_req", {31'd0, iready}, {31'd0, acc});
        read  = 1'b1;
        index = idx;
        a     = baseaddr + idx * 32'd4;
        if (acc) begin
            if (bus) begin
                addr_q.push_back(a);
                addr_q.push_back(a + 32'd2);
            end
            if (push_sb) sb_q.push_back(expd);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sb_q.size() > 0 || addr_q.size() > 0); i++) @(negedge clk);
        check("drain_outputs_left", sb_q.size(), 0);
        check("drain_addrs_left", addr_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int br0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h000a; mem[1] = 16'h000b;
        mem[2] = 16'h0001; mem[3] = 16'h0002;
        mem[4] = 16'h0003; mem[5] = 16'h0004;
        vecs[0] = '{32'd0, 32'h000a000b};
        vecs[1] = '{32'd1, 32'h00010002};
        vecs[2] = '{32'd2, 32'h00030004};

        reset = 1'b1; read = 1'b0; index = '0; baseaddr = '0;
        avm_m0_readdata = '0; avm_m0_readdatavalid = 1'b0; avm_m0_waitrequest = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_ovalid", {31'd0, ovalid}, 32'd0);
        check("rst_read", {31'd0, avm_m0_read}, 32'd0);
        check("rst_iready", {31'd0, iready}, 32'd1);
        check("rst_byteenable", {30'd0, avm_m0_byteenable}, 32'd3);
        check("rst_write", {31'd0, avm_m0_write}, 32'd0);
        check("rst_writedata", {16'd0, avm_m0_writedata}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_address", avm_m0_address, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors issued back to back.
        for (int i = 0; i < 3; i++) req(vecs[i].idx, 1'b1, 1'b1, 1'b1, vecs[i].exp);
        read = 1'b0;
        drain();

        // Stray readdatavalid while idle must not disturb the next block.
        stray = 1'b1;
        repeat (3) @(negedge clk);

        // Waitrequest held for 3 cycles on the first halfword.
        stall_left = 3;
        req(32'd13, 1'b1, 1'b1, 1'b1, blk(32'd13));
        read = 1'b0;
        drain();
        check("stall_consumed", stall_left, 0);

        // Silent memory: fill the FIFO, drop one extra request, then drain in order.
        silent = 1'b1;
        for (int i = 3; i <= 7; i++) req(i, 1'b1, 1'b1, 1'b1, blk(i));
        req(32'd8, 1'b0, 1'b0, 1'b0, 32'd0);
        read = 1'b0;
        repeat (8) @(negedge clk);
        check("iready_full_hold", {31'd0, iready}, 32'd0);
        silent = 1'b0;
        drain();
        check("iready_after_drain", {31'd0, iready}, 32'd1);

        // Re-read of indices 0..2: cache hits or fresh bus fetches depending on build.
        br0 = bus_reads;
        for (int i = 0; i < 3; i++) req(vecs[i].idx, 1'b1, !CACHE, 1'b1, vecs[i].exp);
        read = 1'b0;
        drain();
        check("reread_bus_reads", bus_reads - br0, CACHE ? 0 : 6);

        // Reset mid-transfer: late responses must be ignored, no ovalid.
        silent = 1'b1;
        req(32'd20, 1'b1, 1'b1, 1'b0, 32'd0);
        read = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        silent = 1'b0;
        repeat (8) @(negedge clk);
        check("postrst_iready", {31'd0, iready}, 32'd1);
        check("postrst_read", {31'd0, avm_m0_read}, 32'd0);
        check("postrst_late_rsp_gone", rsp_q.size(), 0);
        req(vecs[1].idx, 1'b1, 1'b1, 1'b1, vecs[1].exp);
        read = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
